// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: single-stage pipelined immediate extender.
// Takes an IN_W-bit immediate and extends it to OUT_W bits in one of four modes:
//   00 sign-extend, 01 zero-extend, 10 place high, 11 sign-extend then shift left 1.
// Uses a valid/ready handshake on both sides and runs at full throughput.
// Optional feature, macro IMM_EXT_PREFIX_EN: a prefix beat latches the upper bits.
// The next non-prefix beat then produces {prefix, imm}.
// Without the macro, in_prefix is ignored and out_prefixed reads 0.
//
// state    | meaning
// IDLE     | no prefix pending; beats are extended per in_mode
// PREFIXED | prefix_reg holds upper bits for the next non-prefix beat

module imm_extend_pipe #(
   parameter int IN_W  = 9,
   parameter int OUT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   input  logic             in_prefix,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_imm,
   output logic             out_prefixed
);

   localparam int EXT_W = OUT_W - IN_W;

   logic             accept;
   logic [OUT_W-1:0] sext;
   logic [OUT_W-1:0] ext_res;

   // Accept a new beat whenever the output slot is empty or is being drained.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign sext     = {{EXT_W{in_imm[IN_W-1]}}, in_imm};

   // Mode-selected extension of the incoming immediate.
   always_comb begin
      ext_res = sext;
      case (in_mode)
         2'b00:   ext_res = sext;
         2'b01:   ext_res = {{EXT_W{1'b0}}, in_imm};
         2'b10:   ext_res = {in_imm, {EXT_W{1'b0}}};
         default: ext_res = {sext[OUT_W-2:0], 1'b0};
      endcase
   end

`ifdef IMM_EXT_PREFIX_EN

   typedef enum logic {IDLE, PREFIXED} state_t;

   state_t           state;
   logic [EXT_W-1:0] prefix_reg;
   logic [EXT_W-1:0] prefix_next;

   // The prefix keeps the low bits of the immediate when it is wide enough.
   // Otherwise the immediate is zero-extended up to the prefix width.
   generate
      if (EXT_W <= IN_W) begin : g_pfx_trunc
         assign prefix_next = in_imm[EXT_W-1:0];
      end else begin : g_pfx_zext
         assign prefix_next = {{(EXT_W-IN_W){1'b0}}, in_imm};
      end
   endgenerate

   // This block handles the prefix state machine and the output register.
   // A prefix beat changes only the state; it never touches the output slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         prefix_reg   <= '0;
         out_valid    <= 1'b0;
         out_imm      <= '0;
         out_prefixed <= 1'b0;
      end else begin
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         if (accept) begin
            if (in_prefix) begin
               state      <= PREFIXED;
               prefix_reg <= prefix_next;
            end else begin
               out_valid <= 1'b1;
               if (state == PREFIXED) begin
                  out_imm      <= {prefix_reg, in_imm};
                  out_prefixed <= 1'b1;
                  state        <= IDLE;
               end else begin
                  out_imm      <= ext_res;
                  out_prefixed <= 1'b0;
               end
            end
         end
      end
   end

`else

   logic unused_prefix;

   assign unused_prefix = in_prefix;
   assign out_prefixed  = 1'b0;

   // Output register: every accepted beat produces a result.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_imm   <= '0;
      end else begin
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         if (accept) begin
            out_valid <= 1'b1;
            out_imm   <= ext_res;
         end
      end
   end

`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Testbench for imm_extend_pipe.
// A scoreboard queue is filled by the driver and drained by an independent monitor.
// Expected values come from an arithmetic model of the extension rules.
// Define IMM_EXT_PREFIX_EN to exercise the prefix feature.

module tb_imm_extend_pipe;

   localparam int IN_W  = 9;
   localparam int OUT_W = 16;
   localparam int EXT_W = OUT_W - IN_W;

   typedef struct {
      logic [OUT_W-1:0] imm;
      logic             pfx;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [IN_W-1:0]  in_imm = '0;
   logic [1:0]       in_mode = '0;
   logic             in_prefix = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [OUT_W-1:0] out_imm;
   logic             out_prefixed;

   int   checks = 0;
   int   errors = 0;
   int   out_cnt = 0;
   int   cyc = 0;
   bit   rand_bp = 1'b0;
   exp_t sb[$];

   // reference-model prefix state
   bit     m_pending = 1'b0;
   longint m_prefix = 0;

   imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
      .in_mode(in_mode), .in_prefix(in_prefix),
      .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
      .out_prefixed(out_prefixed)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the immediate is treated as a signed or unsigned integer.
   // The result is then reduced modulo 2**OUT_W.
   function automatic exp_t model(input longint imm, input int mode, input bit pfx);
      exp_t   e;
      longint m  = longint'(1) << OUT_W;
      longint sv = (imm >= (longint'(1) << (IN_W-1))) ? imm - (longint'(1) << IN_W) : imm;
      e.pfx = 1'b0;
      case (mode)
         0:       e.imm = OUT_W'((sv + m) % m);
         1:       e.imm = OUT_W'(imm);
         2:       e.imm = OUT_W'((imm * (longint'(1) << EXT_W)) % m);
         default: e.imm = OUT_W'((2 * sv + m) % m);
      endcase
`ifdef IMM_EXT_PREFIX_EN
      if (m_pending && !pfx) begin
         e.imm = OUT_W'(m_prefix * (longint'(1) << IN_W) + imm);
         e.pfx = 1'b1;
      end
`endif
      return e;
   endfunction

   // Drive one beat and wait until it is accepted (bounded).
   // Call this task at posedge+1; it returns at posedge+1 after the acceptance edge.
   // exp_override >= 0 replaces the model value with a literal expectation.
   task automatic send(input logic [IN_W-1:0] imm, input logic [1:0] mode,
                       input logic pfx, input int exp_override);
      bit   acc = 1'b0;
      int   n = 0;
      exp_t e;
      in_valid  = 1'b1;
      in_imm    = imm;
      in_mode   = mode;
      in_prefix = pfx;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         n++;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: beat 0x%0h not accepted, required acceptance within 200 cycles", imm);
      end else begin
`ifdef IMM_EXT_PREFIX_EN
         if (pfx) begin
            m_pending = 1'b1;
            m_prefix  = longint'(imm) % (longint'(1) << EXT_W);
         end else begin
            e = model(longint'(imm), int'(mode), pfx);
            m_pending = 1'b0;
            if (exp_override >= 0) e.imm = OUT_W'(exp_override);
            sb.push_back(e);
         end
`else
         e = model(longint'(imm), int'(mode), pfx);
         if (exp_override >= 0) e.imm = OUT_W'(exp_override);
         sb.push_back(e);
`endif
      end
      #1;
      in_valid  = 1'b0;
      in_imm    = IN_W'($urandom);
      in_mode   = 2'($urandom);
      in_prefix = 1'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops and compares on every transfer, and checks stability under stall.
   initial begin : monitor
      bit               held_v = 1'b0;
      logic [OUT_W-1:0] held_imm = '0;
      logic             held_pfx = 1'b0;
      exp_t             e;
      forever begin
         @(negedge clk);
         if (rst) begin
            held_v = 1'b0;
         end else begin
            chk("in_ready_rule", in_ready, !out_valid || out_ready);
            if (held_v && out_valid) begin
               chk("hold_imm", out_imm, held_imm);
               chk("hold_pfx", out_prefixed, held_pfx);
            end
            if (out_valid && out_ready) begin
               out_cnt++;
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output: got 0x%0h, required no output", out_imm);
               end else begin
                  e = sb.pop_front();
                  chk("out_imm", out_imm, e.imm);
                  chk("out_prefixed", out_prefixed, e.pfx);
               end
            end
            held_v   = out_valid && !out_ready;
            held_imm = out_imm;
            held_pfx = out_prefixed;
         end
      end
   end

   // Random backpressure, active only during the random phase.
   initial begin : bp_gen
      forever begin
         @(posedge clk);
         #1;
         if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin : stim
      int c0;
      int o0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_imm", out_imm, 0);
      chk("rst_out_prefixed", out_prefixed, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // sign-extension cases with literal expectations
      send(9'h1AE, 2'b00, 1'b0, 16'hFFAE);
      send(9'h0FF, 2'b00, 1'b0, 16'h00FF);
      send(9'h100, 2'b00, 1'b0, 16'hFF00);
      send(9'h000, 2'b00, 1'b0, 16'h0000);
      send(9'h1AE, 2'b01, 1'b0, 16'h01AE);
      send(9'h1FF, 2'b10, 1'b0, 16'hFF80);
      send(9'h1FF, 2'b11, 1'b0, 16'hFFFE);
      send(9'h0FF, 2'b11, 1'b0, 16'h01FE);
      drain();

`ifdef IMM_EXT_PREFIX_EN
      send(9'h055, 2'b00, 1'b1, -1);
      send(9'h1AE, 2'b00, 1'b0, 16'hABAE);
      send(9'h1AE, 2'b00, 1'b0, 16'hFFAE);
      // a second prefix overwrites the first; the mode of the next beat is ignored
      send(9'h011, 2'b00, 1'b1, -1);
      send(9'h07F, 2'b00, 1'b1, -1);
      send(9'h001, 2'b10, 1'b0, 16'hFE01);
`else
      // in_prefix is ignored when the prefix feature is absent
      send(9'h055, 2'b00, 1'b1, 16'h0055);
      send(9'h1AE, 2'b00, 1'b1, 16'hFFAE);
`endif
      drain();

      // backpressure: the first result is held and the second beat stalls
      out_ready = 1'b0;
      send(9'h1AE, 2'b00, 1'b0, 16'hFFAE);
      fork
         send(9'h07F, 2'b00, 1'b0, 16'h007F);
         begin
            repeat (3) begin
               @(negedge clk);
               chk("bp_in_ready", in_ready, 0);
               chk("bp_out_imm", out_imm, 16'hFFAE);
               chk("bp_out_valid", out_valid, 1);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // back-to-back: 8 beats accepted in 8 cycles with 8 results
      c0 = cyc;
      o0 = out_cnt;
      for (int i = 0; i < 8; i++)
         send(IN_W'($urandom), 2'($urandom), 1'b0, -1);
      chk("b2b_cycles", cyc - c0, 8);
      @(negedge clk);
      chk("b2b_results", out_cnt - o0, 8);
      drain();

      // reset: a pending prefix and the output are discarded
`ifdef IMM_EXT_PREFIX_EN
      send(9'h055, 2'b00, 1'b1, -1);
`endif
      out_ready = 1'b0;
      send(9'h033, 2'b01, 1'b0, -1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_prefixed", out_prefixed, 0);
      void'(sb.pop_back());
      m_pending = 1'b0;
      rst = 1'b0;
      out_ready = 1'b1;
      send(9'h1AE, 2'b00, 1'b0, 16'hFFAE);
      drain();

      // randomized traffic with random gaps and random backpressure
      rand_bp = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         send(IN_W'($urandom), 2'($urandom), ($urandom_range(0, 9) == 0), -1);
      end
      rand_bp = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
